fir_filter: RTL and testbench

- 8-tap direct-form FIR filter with fixed unsigned coefficients, driven by a sample-valid strobe.
- Sits in the sample datapath. Consumes one 8-bit unsigned sample per valid_in pulse and produces one 15-bit filtered result per accepted sample.
- Result is registered and held until the next accepted sample.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_tap_mult.sv | 21 ++
 rtl/fir_filter.sv | 91 +++++++++
 tb/tb_fir_filter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared widths, types and fixed coefficient set for the
//                8-tap direct-form FIR filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  // Datapath widths
  localparam int DATA_W = 8;
  localparam int COEF_W = 4;
  localparam int NTAPS  = 8;
  localparam int OUT_W  = 15;

  // A single tap product carries the full sample x coefficient precision
  localparam int PROD_W = DATA_W + COEF_W;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [OUT_W-1:0]  acc_t;

  // Symmetric low-pass kernel; sum = 30, so 255*30 = 7650 fits in OUT_W bits
  localparam coef_t COEFS [0:NTAPS-1] = '{
    4'd1, 4'd2, 4'd4, 4'd8, 4'd8, 4'd4, 4'd2, 4'd1
  };

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_tap_mult.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tap_mult
//  Description : Unsigned sample multiplied by a constant coefficient.
//                Purely combinational; one instance per filter tap.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_mult
  import fir_pkg::*;
#(
  parameter coef_t COEF = '0
) (
  input  sample_t sample,
  output prod_t   product
);

  // Both operands widened to the product width so no bits are lost
  assign product = prod_t'(sample) * prod_t'(COEF);

endmodule : fir_tap_mult
`default_nettype wire

// File: rtl/fir_filter.sv
`default_nettype none
// ============================================================================
//  Module      : fir_filter
//  Description : 8-tap direct-form FIR with fixed unsigned coefficients.
//                One sample accepted per valid_in; registered result with a
//                one-cycle valid_out pulse, held until the next sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_filter
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [OUT_W-1:0]  data_out,
  output logic              valid_out
);

  // x1..x7 : previously accepted samples, x1 the most recent
  sample_t delay_line [1:NTAPS-1];

  // Tap inputs: tap 0 is the live sample, taps 1..7 are the delay line
  sample_t taps     [0:NTAPS-1];
  prod_t   products [0:NTAPS-1];

  // Adder tree levels, each its own array so no level depends on itself
  acc_t    lvl0 [0:NTAPS-1];
  acc_t    lvl1 [0:NTAPS/2-1];
  acc_t    lvl2 [0:NTAPS/4-1];
  acc_t    sum;

  assign taps[0] = data_in;

  generate
    for (genvar k = 1; k < NTAPS; k++) begin : g_taps
      assign taps[k] = delay_line[k];
    end

    for (genvar i = 0; i < NTAPS; i++) begin : g_mult
      fir_tap_mult #(
        .COEF (COEFS[i])
      ) u_mult (
        .sample  (taps[i]),
        .product (products[i])
      );
      // Zero-extend each product to the accumulator width before summing
      assign lvl0[i] = acc_t'(products[i]);
    end

    for (genvar j = 0; j < NTAPS/2; j++) begin : g_lvl1
      assign lvl1[j] = lvl0[2*j] + lvl0[2*j+1];
    end

    for (genvar j = 0; j < NTAPS/4; j++) begin : g_lvl2
      assign lvl2[j] = lvl1[2*j] + lvl1[2*j+1];
    end
  endgenerate

  // Final level of the three-level tree for eight taps
  assign sum = lvl2[0] + lvl2[1];

  // Delay line shifts only on accepted samples; idle cycles ignore data_in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < NTAPS; k++) begin
        delay_line[k] <= '0;
      end
    end else if (valid_in) begin
      delay_line[1] <= data_in;
      for (int k = 2; k < NTAPS; k++) begin
        delay_line[k] <= delay_line[k-1];
      end
    end
  end

  // Output register captures the tree sum of pre-edge history; valid tracks valid_in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        data_out <= sum;
      end
    end
  end

endmodule : fir_filter
`default_nettype wire

// File: tb/tb_fir_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_filter
//  Description : Self-checking bench for fir_filter with a reference model
//                and a scoreboard queue of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_filter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [14:0] data_out;
  logic        valid_out;

  int checks   = 0;
  int failures = 0;

  // Reference model state: hist[0] is newest accepted sample
  int unsigned hist [0:7];
  int unsigned coef [0:7] = '{1, 2, 4, 8, 8, 4, 2, 1};
  int unsigned exp_q [$];
  int unsigned last_out = 0;

  fir_filter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) hist[i] = 0;
    exp_q.delete();
    last_out = 0;
  endtask

  // Drive one accepted sample, push the model result, then pop and compare
  task automatic send(input logic [7:0] s, input string tag);
    int unsigned acc;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    acc = 0;
    for (int i = 0; i < 8; i++) acc += coef[i] * hist[i];
    exp_q.push_back(acc);
    data_in  = s;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
        last_out = exp_q.pop_front();
        check({tag, "_data"}, {17'd0, data_out}, last_out);
      end
    end else begin
      if (exp_q.size() != 0) last_out = exp_q.pop_front();
    end
  endtask

  // Idle cycles: outputs must hold; optional X / random noise on data_in
  task automatic idle(input int n, input bit noisy, input string tag);
    valid_in = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (noisy) data_in = (c % 2 == 0) ? 8'bx : 8'($urandom_range(0, 255));
      else       data_in = 8'd0;
      @(posedge clk);
      #1;
      check({tag, "_valid_low"}, {31'd0, valid_out}, 32'd0);
      check({tag, "_hold"}, {17'd0, data_out}, last_out);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    data_in  = 8'd0;
    valid_in = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", {17'd0, data_out}, 32'd0);
    check("reset_valid", {31'd0, valid_out}, 32'd0);
    rst_n = 1'b1;
    idle(3, 1'b0, "post_reset");

    // Impulse sequence: 1, 7, 12 separated by idle -> 1, 9, 30
    send(8'd1, "imp_a");
    idle(10, 1'b0, "imp_a_idle");
    send(8'd7, "imp_b");
    check("imp_b_value", {17'd0, data_out}, 32'd9);
    idle(10, 1'b0, "imp_b_idle");
    send(8'd12, "imp_c");
    check("imp_c_value", {17'd0, data_out}, 32'd30);
    idle(2, 1'b0, "imp_c_idle");

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", {17'd0, data_out}, 32'd0);
    check("async_rst_valid", {31'd0, valid_out}, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2, 1'b0, "async_rst_idle");

    // Impulse response: 1 then seven zeros, then a ninth zero
    send(8'd1, "ir0");
    check("ir0_value", {17'd0, data_out}, 32'd1);
    send(8'd0, "ir1");
    send(8'd0, "ir2");
    send(8'd0, "ir3");
    check("ir3_value", {17'd0, data_out}, 32'd8);
    send(8'd0, "ir4");
    send(8'd0, "ir5");
    send(8'd0, "ir6");
    send(8'd0, "ir7");
    check("ir7_value", {17'd0, data_out}, 32'd1);
    send(8'd0, "ir8");
    check("ir8_value", {17'd0, data_out}, 32'd0);
    idle(2, 1'b0, "ir_idle");

    // Full-scale back-to-back: eight samples of 255 -> ramps to 7650
    for (int i = 0; i < 8; i++) send(8'd255, "full");
    check("full_final", {17'd0, data_out}, 32'd7650);
    idle(2, 1'b0, "full_idle");

    // Reset mid-stream: history discarded before the next sample
    send(8'd10, "pre_rst");
    send(8'd10, "pre_rst");
    send(8'd10, "pre_rst");
    rst_n = 1'b0;
    valid_in = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    send(8'd5, "post_rst");
    check("post_rst_value", {17'd0, data_out}, 32'd5);

    // Idle immunity: build known history, then noise with valid_in low
    send(8'd3, "hist_a");
    send(8'd9, "hist_b");
    idle(20, 1'b1, "noise");
    send(8'd4, "after_noise");
    check("after_noise_value", {17'd0, data_out}, 32'd4 + 32'd18 + 32'd12 + 32'd40);
    idle(2, 1'b0, "final_idle");

    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fir_filter
`default_nettype wire
